// File: rtl/jtcop_sndbus_pkg.sv
// Shared types and field layout for the jtcop_sndbus sound-CPU bus controller.
package jtcop_sndbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_GAP
  } nmi_state_t;

  localparam int PAGE_W = 5;

  // Each DEV_MAP entry is {page[4:0], a15}; page[4] is not compared.
  localparam int DEV_W        = 6;
  localparam int DEV_A15_BIT  = 0;
  localparam int DEV_PAGE_LSB = 1;
  localparam int DEV_CMP_W    = 5;

endpackage

// File: rtl/jtcop_sndbus_fifo.sv
// Command FIFO between main CPU and sound CPU; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module jtcop_sndbus_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtcop_sndbus.sv
// HuC6280 sound-CPU bus controller: chip selects, read mux, ROM wait, command
// FIFO and NMI pacing. Define SNDBUS_STATUS_EN to add the status[7:0] output.
module jtcop_sndbus
  import jtcop_sndbus_pkg::*;
#(
  parameter int                      AW         = 21,
  parameter int                      NDEV       = 4,
  parameter logic [DEV_W*NDEV-1:0]   DEV_MAP    = {NDEV{6'h00}},
  parameter logic [PAGE_W-1:0]       LATCH_PAGE = 5'h03,
  parameter logic [PAGE_W-1:0]       RAM_PAGE   = 5'h1F,
  parameter int                      DEPTH      = 4,
  parameter int                      NMI_GAP    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sx,
  input  logic                     ce,
  input  logic                     wrn,
  input  logic [AW-1:0]            addr,
  output logic [7:0]               cpu_din,
  output logic                     rom_cs,
  input  logic [7:0]               rom_data,
  input  logic                     rom_ok,
  output logic                     wait_n,
  output logic                     ram_cs,
  input  logic [7:0]               ram_dout,
  output logic [NDEV-1:0]          dev_cs,
  input  logic [8*NDEV-1:0]        dev_dout,
  input  logic                     snreq,
  input  logic [7:0]               latch,
  output logic                     nmi_n,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overrun
`ifdef SNDBUS_STATUS_EN
  ,
  output logic [7:0]               status
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (NMI_GAP > 1) ? $clog2(NMI_GAP) : 1;

  logic [PAGE_W-1:0] page;
  logic [NDEV-1:0]   dev_hit;
  logic              latch_cs;
  logic              snreq_r;
  logic              push;
  logic              pop_req;
  logic              pop_done;
  logic [7:0]        head;
  logic [7:0]        rd_mux;
  logic              full;
  logic              empty;
  nmi_state_t        state;
  nmi_state_t        state_nx;
  logic [CW-1:0]     gap_cnt;
  logic [CW-1:0]     gap_cnt_nx;

  assign page = addr[AW-1 -: PAGE_W];

  always_comb begin
    dev_hit = '0;
    for (int i = 0; i < NDEV; i++)
      dev_hit[i] = addr[AW-1] &&
        ({page[PAGE_W-2:0], addr[15]} == DEV_MAP[DEV_W*i +: DEV_CMP_W]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cs   <= 1'b0;
      ram_cs   <= 1'b0;
      latch_cs <= 1'b0;
      dev_cs   <= '0;
    end else if (sx) begin
      rom_cs   <= (page == '0);
      ram_cs   <= (page == RAM_PAGE);
      latch_cs <= (page == LATCH_PAGE) && addr[15];
      dev_cs   <= dev_hit;
    end else if (ce) begin
      rom_cs   <= 1'b0;
      ram_cs   <= 1'b0;
      latch_cs <= 1'b0;
      dev_cs   <= '0;
    end
  end

  // Later assignments win: ram > dev[0] > ... > dev[NDEV-1] > latch > rom.
  always_comb begin
    rd_mux = 8'hFF;
    if (rom_cs)   rd_mux = rom_data;
    if (latch_cs) rd_mux = empty ? 8'hFF : head;
    for (int i = NDEV-1; i >= 0; i--)
      if (dev_cs[i]) rd_mux = dev_dout[8*i +: 8];
    if (ram_cs)   rd_mux = ram_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_din <= 8'hFF;
      wait_n  <= 1'b1;
    end else begin
      cpu_din <= rd_mux;
      wait_n  <= !rom_cs || rom_ok;
    end
  end

  assign push    = snreq && !snreq_r;
  assign pop_req = latch_cs && wrn && !pop_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snreq_r  <= 1'b0;
      pop_done <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      snreq_r  <= snreq;
      pop_done <= latch_cs && (pop_done || pop_req);
      overrun  <= overrun || (push && full && !pop_req);
    end
  end

  jtcop_sndbus_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop_req),
    .din   (latch),
    .head  (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    gap_cnt_nx = gap_cnt;
    nmi_n      = 1'b1;
    case (state)
      ST_IDLE: if (!empty) state_nx = ST_ASSERT;
      ST_ASSERT: begin
        nmi_n = 1'b0;
        if (pop_req) begin
          state_nx   = ST_GAP;
          gap_cnt_nx = CW'(NMI_GAP - 1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_nx = empty ? ST_IDLE : ST_ASSERT;
        else               gap_cnt_nx = gap_cnt - 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

`ifdef SNDBUS_STATUS_EN
  logic [2:0] level3;
  assign level3 = 3'(fifo_level);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) status <= 8'h80;
    else     status <= {nmi_n, overrun, level3, head[2:0]};
  end
`endif

endmodule

// File: tb/tb_jtcop_sndbus.sv
// Self-checking bench for jtcop_sndbus: decode table, directed command/NMI
// sequences and a randomized run against a queue-based reference model.
module tb_jtcop_sndbus;

  localparam int AW      = 21;
  localparam int NDEV    = 4;
  localparam int DEPTH   = 4;
  localparam int NMI_GAP = 8;
  // dev0={10,0} dev1={11,1} dev2={12,1} dev3={13,0}
  localparam logic [6*NDEV-1:0] DEV_MAP_TB = 24'h9A58E0;
  localparam logic [AW-1:0] LATCH_ADDR = 21'h038000;

  logic              clk = 1'b0;
  logic              rst, sx, ce, wrn, rom_ok, snreq;
  logic [AW-1:0]     addr;
  logic [7:0]        rom_data, ram_dout, latch;
  logic [8*NDEV-1:0] dev_dout;
  logic [7:0]        cpu_din;
  logic              rom_cs, wait_n, ram_cs, nmi_n, overrun;
  logic [NDEV-1:0]   dev_cs;
  logic [2:0]        fifo_level;

  int total = 0;
  int bad   = 0;

  jtcop_sndbus #(
    .AW(AW), .NDEV(NDEV), .DEV_MAP(DEV_MAP_TB), .LATCH_PAGE(5'h03),
    .RAM_PAGE(5'h1F), .DEPTH(DEPTH), .NMI_GAP(NMI_GAP)
  ) dut (
    .clk(clk), .rst(rst), .sx(sx), .ce(ce), .wrn(wrn), .addr(addr),
    .cpu_din(cpu_din), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .wait_n(wait_n), .ram_cs(ram_cs), .ram_dout(ram_dout), .dev_cs(dev_cs),
    .dev_dout(dev_dout), .snreq(snreq), .latch(latch), .nmi_n(nmi_n),
    .fifo_level(fifo_level), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit              m_rom, m_ram, m_lat, m_wait, m_ovr, m_snq, m_popd;
  logic [NDEV-1:0] m_dev;
  logic [7:0]      m_din;
  logic [7:0]      q[$];

  function automatic logic [NDEV-1:0] ref_dev(input logic [AW-1:0] a);
    logic [5:0] e;
    ref_dev = '0;
    for (int i = 0; i < NDEV; i++) begin
      e = DEV_MAP_TB[6*i +: 6];
      ref_dev[i] = a[20] && (e[4:1] == a[19:16]) && (e[0] == a[15]);
    end
  endfunction

  task automatic model_step();
    logic [7:0] rd;
    bit pop_now, push_now, found;
    if (rst) begin
      m_rom = 0; m_ram = 0; m_lat = 0; m_dev = '0; m_din = 8'hFF; m_wait = 1;
      m_ovr = 0; m_snq = 0; m_popd = 0; q.delete();
      return;
    end
    rd = 8'hFF;
    found = 0;
    if (m_ram) rd = ram_dout;
    else begin
      for (int i = 0; i < NDEV; i++)
        if (!found && m_dev[i]) begin rd = dev_dout[8*i +: 8]; found = 1; end
      if (!found) begin
        if (m_lat)      rd = (q.size() != 0) ? q[0] : 8'hFF;
        else if (m_rom) rd = rom_data;
      end
    end
    m_din  = rd;
    m_wait = !m_rom || rom_ok;
    pop_now  = m_lat && wrn && !m_popd;
    m_popd   = m_lat && (m_popd || pop_now);
    push_now = snreq && !m_snq;
    m_snq    = snreq;
    if (pop_now && q.size() != 0) void'(q.pop_front());
    if (push_now) begin
      if (q.size() < DEPTH) q.push_back(latch);
      else m_ovr = 1;
    end
    if (sx) begin
      m_rom = (addr[20:16] == 5'h00);
      m_ram = (addr[20:16] == 5'h1F);
      m_lat = (addr[20:16] == 5'h03) && addr[15];
      m_dev = ref_dev(addr);
    end else if (ce) begin
      m_rom = 0; m_ram = 0; m_lat = 0; m_dev = '0;
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  // ---------------- helpers ----------------
  int   hi_run, falls, min_gap;
  logic nmi_prev;

  task automatic tick();
    @(posedge clk); #1;
    if (nmi_n) hi_run++;
    else begin
      if (nmi_prev) begin
        falls++;
        if (falls > 1 && hi_run < min_gap) min_gap = hi_run;
      end
      hi_run = 0;
    end
    nmi_prev = nmi_n;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    latch = b; snreq = 1; tick();
    snreq = 0; tick();
  endtask

  task automatic read_latch(output logic [7:0] v);
    addr = LATCH_ADDR; wrn = 1; sx = 1; tick();
    sx = 0; tick();
    v = cpu_din;
    ce = 1; tick();
    ce = 0;
  endtask

  task automatic wait_nmi_low();
    int n = 0;
    while (nmi_n === 1'b1 && n < 200) begin tick(); n++; end
    chk("nmi_wait", nmi_n, 1'b0);
  endtask

  typedef struct {
    logic          sx;
    logic          ce;
    logic [AW-1:0] a;
    logic          rom;
    logic          ram;
    logic [3:0]    dev;
  } dec_vec_t;

  dec_vec_t vt[12];

  initial begin
    logic [7:0] v;
    int hcnt;
    vt[0]  = '{1'b1, 1'b0, 21'h001234, 1'b1, 1'b0, 4'b0000};
    vt[1]  = '{1'b1, 1'b0, 21'h1F0010, 1'b0, 1'b1, 4'b0000};
    vt[2]  = '{1'b1, 1'b0, 21'h118000, 1'b0, 1'b0, 4'b0010};
    vt[3]  = '{1'b0, 1'b0, 21'h000000, 1'b0, 1'b0, 4'b0010};
    vt[4]  = '{1'b0, 1'b1, 21'h000000, 1'b0, 1'b0, 4'b0000};
    vt[5]  = '{1'b1, 1'b0, 21'h100000, 1'b0, 1'b0, 4'b0001};
    vt[6]  = '{1'b1, 1'b0, 21'h128000, 1'b0, 1'b0, 4'b0100};
    vt[7]  = '{1'b1, 1'b0, 21'h130000, 1'b0, 1'b0, 4'b1000};
    vt[8]  = '{1'b1, 1'b0, 21'h018000, 1'b0, 1'b0, 4'b0000};
    vt[9]  = '{1'b1, 1'b0, 21'h138000, 1'b0, 1'b0, 4'b0000};
    vt[10] = '{1'b1, 1'b0, 21'h030000, 1'b0, 1'b0, 4'b0000};
    vt[11] = '{1'b1, 1'b1, 21'h001FFF, 1'b1, 1'b0, 4'b0000};

    hi_run = 0; falls = 0; min_gap = 1000; nmi_prev = 1;
    rst = 1; sx = 0; ce = 0; wrn = 1; rom_ok = 0; snreq = 0; addr = '0;
    rom_data = 0; ram_dout = 0; latch = 0; dev_dout = '0;
    tick(); tick();
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_dev_cs", dev_cs, 0);
    chk("rst_cpu_din", cpu_din, 8'hFF);
    chk("rst_wait_n", wait_n, 1);
    chk("rst_nmi_n", nmi_n, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_overrun", overrun, 0);
    rst = 0; tick();

    // ROM select and wait
    addr = 21'h001234; rom_data = 8'h5A; rom_ok = 0; sx = 1; tick();
    chk("rom_cs", rom_cs, 1);
    sx = 0;
    for (int i = 0; i < 5; i++) begin tick(); chk("rom_wait_low", wait_n, 0); end
    rom_ok = 1; tick();
    chk("rom_wait_high", wait_n, 1);
    chk("rom_data", cpu_din, 8'h5A);
    ce = 1; tick(); ce = 0;
    chk("rom_ce_clear", rom_cs, 0);

    // device decode
    dev_dout = 32'h4433C311; addr = 21'h118000; sx = 1; tick();
    chk("dev1_cs", dev_cs, 4'b0010);
    sx = 0; tick();
    chk("dev1_data", cpu_din, 8'hC3);
    ce = 1; tick(); ce = 0;
    chk("dev1_ce_clear", dev_cs, 4'b0000);

    // decode table
    for (int i = 0; i < 12; i++) begin
      sx = vt[i].sx; ce = vt[i].ce; addr = vt[i].a;
      tick();
      chk($sformatf("tab%0d_rom", i), rom_cs, vt[i].rom);
      chk($sformatf("tab%0d_ram", i), ram_cs, vt[i].ram);
      chk($sformatf("tab%0d_dev", i), dev_cs, vt[i].dev);
    end
    sx = 0; ce = 1; tick(); ce = 0; tick();

    // single command
    latch = 8'h42; snreq = 1; tick();
    chk("cmd_level1", fifo_level, 1);
    snreq = 0; tick();
    chk("cmd_nmi_low", nmi_n, 0);
    addr = LATCH_ADDR; wrn = 1; sx = 1; tick();
    sx = 0; tick();
    chk("cmd_read", cpu_din, 8'h42);
    chk("cmd_level0", fifo_level, 0);
    chk("cmd_nmi_high", nmi_n, 1);
    ce = 1; tick(); ce = 0;
    hcnt = 0;
    for (int i = 0; i < 7; i++) begin tick(); if (nmi_n) hcnt++; end
    chk("cmd_gap_high", hcnt, 7);

    // back-to-back commands
    hi_run = 0; falls = 0; min_gap = 1000; nmi_prev = nmi_n;
    send_cmd(8'h10); send_cmd(8'h11); send_cmd(8'h12);
    chk("b2b_level3", fifo_level, 3);
    for (int k = 0; k < 3; k++) begin
      wait_nmi_low();
      read_latch(v);
      chk($sformatf("b2b_read%0d", k), v, 8'h10 + k);
    end
    chk("b2b_nmi_pulses", falls, 3);
    chk("b2b_gap_ok", min_gap >= NMI_GAP, 1);
    chk("b2b_level0", fifo_level, 0);

    // overrun
    for (int k = 0; k < 5; k++) send_cmd(8'hA0 + k);
    chk("ovr_level", fifo_level, 4);
    chk("ovr_flag", overrun, 1);
    for (int k = 0; k < 4; k++) begin
      wait_nmi_low();
      read_latch(v);
      chk($sformatf("ovr_read%0d", k), v, 8'hA0 + k);
    end
    read_latch(v);
    chk("ovr_empty_read", v, 8'hFF);
    chk("ovr_sticky", overrun, 1);

    // reset mid-burst
    addr = 21'h001234; rom_data = 8'h77; rom_ok = 1; sx = 1; tick();
    sx = 0; tick();
    send_cmd(8'hB0); send_cmd(8'hB1);
    wait_nmi_low();
    chk("mid_level2", fifo_level, 2);
    chk("mid_din", cpu_din, 8'h77);
    rst = 1; #1;
    chk("mid_rst_nmi", nmi_n, 1);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_din", cpu_din, 8'hFF);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_rom", rom_cs, 0);
    tick(); tick();
    rst = 0; tick();

    // randomized run against the reference model
    for (int c = 0; c < 1500; c++) begin
      sx = ($urandom % 3) == 0;
      case ($urandom % 6)
        0: addr = {5'h00, 16'($urandom)};
        1: addr = {5'h1F, 16'($urandom)};
        2: addr = {5'h03, 1'b1, 15'($urandom)};
        3: addr = {5'h03, 16'($urandom)};
        4: addr = {3'b100, 2'($urandom), 16'($urandom)};
        default: addr = 21'($urandom);
      endcase
      ce       = ($urandom % 3) == 0;
      wrn      = ($urandom % 4) != 0;
      rom_ok   = $urandom % 2;
      rom_data = 8'($urandom);
      ram_dout = 8'($urandom);
      dev_dout = 32'($urandom);
      snreq    = ($urandom % 5) == 0;
      latch    = 8'($urandom);
      tick();
      chk("rnd_rom_cs", rom_cs, m_rom);
      chk("rnd_ram_cs", ram_cs, m_ram);
      chk("rnd_dev_cs", dev_cs, m_dev);
      chk("rnd_cpu_din", cpu_din, m_din);
      chk("rnd_wait_n", wait_n, m_wait);
      chk("rnd_level", fifo_level, q.size());
      chk("rnd_overrun", overrun, m_ovr);
      chk("rnd_nmi_needs_cmd", (!nmi_n) && (q.size() == 0), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
